// File: rtl/sc_stream_to_bin.sv
// Stochastic-to-binary decoder: counts the 1s on a bitstream over a 2**WIDTH-cycle
// window and presents the count through a valid/ready handshake.
module sc_stream_to_bin #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stream,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   result
);

    localparam int unsigned CNT_W = WIDTH + 1;
    // Cycle-counter value during the final sample of the window.
    localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'((64'd1 << WIDTH) - 64'd1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cycle_q;
    logic [CNT_W-1:0]   cycle_d;
    logic [CNT_W-1:0]   ones_q;
    logic [CNT_W-1:0]   ones_d;
    logic [CNT_W-1:0]   result_d;
    logic               busy_d;
    logic               out_valid_d;

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cycle_q   <= '0;
            ones_q    <= '0;
            result    <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            cycle_q   <= cycle_d;
            ones_q    <= ones_d;
            result    <= result_d;
            busy      <= busy_d;
            out_valid <= out_valid_d;
        end
    end

    // Next-state, counter and output logic.
    always_comb begin
        state_d  = state_q;
        cycle_d  = cycle_q;
        ones_d   = ones_q;
        result_d = result;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = COUNT;
                    cycle_d = '0;
                    ones_d  = '0;
                end
            end
            COUNT: begin
                ones_d  = ones_q + CNT_W'(stream);
                cycle_d = cycle_q + CNT_W'(1);
                // Last sample lands directly in the result so DONE presents it at once.
                if (cycle_q == LAST_SAMPLE) begin
                    state_d  = DONE;
                    result_d = ones_d;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered from the next state, so they carry no input-to-output path.
        busy_d      = (state_d != IDLE);
        out_valid_d = (state_d == DONE);
    end

endmodule
